// File: rtl/lcd_timing_pkg.sv
// Shared panel constants for the LCD raster timing and its downstream consumers.
// The counter width and the total-period limit also live here.
package lcd_timing_pkg;

  localparam int unsigned CntW = 11;
  localparam int unsigned MaxTotal = 2047;

  localparam int unsigned DefLcdWidth  = 480;
  localparam int unsigned DefLcdHeight = 280;
  localparam int unsigned DefHFp       = 8;
  localparam int unsigned DefHSync     = 4;
  localparam int unsigned DefHBp       = 43;
  localparam int unsigned DefVFp       = 8;
  localparam int unsigned DefVSync     = 4;
  localparam int unsigned DefVBp       = 12;

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  localparam int unsigned DefHTotal = axis_total(DefLcdWidth, DefHFp, DefHSync, DefHBp);
  localparam int unsigned DefVTotal = axis_total(DefLcdHeight, DefVFp, DefVSync, DefVBp);

endpackage

// File: rtl/lcd_timing_axis.sv
// One raster axis: a wrapping counter that advances on STEP, with unregistered
// active/sync/last decodes of the current count.
module lcd_timing_axis
  import lcd_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = 480,
  parameter int unsigned FP     = 8,
  parameter int unsigned SYNC   = 4,
  parameter int unsigned BP     = 43
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            STEP,
  output logic [CntW-1:0] CNT,
  output logic            ACTIVE_O,
  output logic            SYNC_N,
  output logic            LAST
);

  localparam int unsigned Total = axis_total(ACTIVE, FP, SYNC, BP);

  localparam logic [CntW-1:0] CntLast   = CntW'(Total - 1);
  localparam logic [CntW-1:0] CntActive = CntW'(ACTIVE);
  localparam logic [CntW-1:0] SyncLo    = CntW'(ACTIVE + FP);
  localparam logic [CntW-1:0] SyncHi    = CntW'(ACTIVE + FP + SYNC);

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;

  always_comb begin
    w_cnt_d = r_cnt;
    if (STEP) begin
      w_cnt_d = LAST ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

  assign CNT      = r_cnt;
  assign LAST     = (r_cnt == CntLast);
  assign ACTIVE_O = (r_cnt < CntActive);
  assign SYNC_N   = !((r_cnt >= SyncLo) && (r_cnt < SyncHi));

endmodule

// File: rtl/lcd_timing.sv
// Parallel RGB LCD raster timing: free-running H/V counters with every output
// decoded from the counters and registered one clock later.
module lcd_timing
  import lcd_timing_pkg::*;
#(
  parameter int unsigned LCD_WIDTH  = DefLcdWidth,
  parameter int unsigned LCD_HEIGHT = DefLcdHeight,
  parameter int unsigned H_FP       = DefHFp,
  parameter int unsigned H_SYNC     = DefHSync,
  parameter int unsigned H_BP       = DefHBp,
  parameter int unsigned V_FP       = DefVFp,
  parameter int unsigned V_SYNC     = DefVSync,
  parameter int unsigned V_BP       = DefVBp
) (
  input  logic            CLK,
  input  logic            RST,
  output logic            HSYNC,
  output logic            VSYNC,
  output logic            DEN,
  output logic [CntW-1:0] X,
  output logic [CntW-1:0] Y,
  output logic            FRAME_START
);

  localparam int unsigned HTotal = axis_total(LCD_WIDTH, H_FP, H_SYNC, H_BP);
  localparam int unsigned VTotal = axis_total(LCD_HEIGHT, V_FP, V_SYNC, V_BP);

  if (HTotal > MaxTotal) begin : g_h_total_too_big
    $error("lcd_timing: H_TOTAL exceeds 2047");
  end
  if (VTotal > MaxTotal) begin : g_v_total_too_big
    $error("lcd_timing: V_TOTAL exceeds 2047");
  end

  logic [CntW-1:0] w_h_cnt, w_v_cnt;
  logic            w_h_active, w_v_active;
  logic            w_h_sync_n, w_v_sync_n;
  logic            w_h_last, w_v_last;
  logic            w_den;

  lcd_timing_axis #(
    .ACTIVE(LCD_WIDTH),
    .FP    (H_FP),
    .SYNC  (H_SYNC),
    .BP    (H_BP)
  ) u_h_axis (
    .CLK     (CLK),
    .RST     (RST),
    .STEP    (1'b1),
    .CNT     (w_h_cnt),
    .ACTIVE_O(w_h_active),
    .SYNC_N  (w_h_sync_n),
    .LAST    (w_h_last)
  );

  // Vertical advances once per line, on the last horizontal count.
  lcd_timing_axis #(
    .ACTIVE(LCD_HEIGHT),
    .FP    (V_FP),
    .SYNC  (V_SYNC),
    .BP    (V_BP)
  ) u_v_axis (
    .CLK     (CLK),
    .RST     (RST),
    .STEP    (w_h_last),
    .CNT     (w_v_cnt),
    .ACTIVE_O(w_v_active),
    .SYNC_N  (w_v_sync_n),
    .LAST    (w_v_last)
  );

  assign w_den = w_h_active && w_v_active;

  logic            r_hsync, r_vsync, r_den, r_frame_start;
  logic [CntW-1:0] r_x, r_y;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_den         <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_hsync       <= w_h_sync_n;
      r_vsync       <= w_v_sync_n;
      r_den         <= w_den;
      r_x           <= w_den ? w_h_cnt : '0;
      r_y           <= w_den ? w_v_cnt : '0;
      r_frame_start <= (w_h_cnt == '0) && (w_v_cnt == '0);
    end
  end

  assign HSYNC       = r_hsync;
  assign VSYNC       = r_vsync;
  assign DEN         = r_den;
  assign X           = r_x;
  assign Y           = r_y;
  assign FRAME_START = r_frame_start;

  // The vertical wrap is implied by the counters; kept visible for lint.
  logic w_unused;
  assign w_unused = w_v_last;

endmodule

// File: tb/tb_lcd_timing.sv
// Directed bench: a default-size panel for reset/line/mid-frame behaviour and a
// 16x4 panel (19x7 totals) for full-frame and wrap behaviour.
module tb_lcd_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d = 1'b1;
  logic rst_s = 1'b1;

  logic        hs_d, vs_d, den_d, fs_d;
  logic [10:0] x_d, y_d;
  logic        hs_s, vs_s, den_s, fs_s;
  logic [10:0] x_s, y_s;

  lcd_timing u_dut_def (
    .CLK        (clk),
    .RST        (rst_d),
    .HSYNC      (hs_d),
    .VSYNC      (vs_d),
    .DEN        (den_d),
    .X          (x_d),
    .Y          (y_d),
    .FRAME_START(fs_d)
  );

  lcd_timing #(
    .LCD_WIDTH (16),
    .LCD_HEIGHT(4),
    .H_FP      (1),
    .H_SYNC    (1),
    .H_BP      (1),
    .V_FP      (1),
    .V_SYNC    (1),
    .V_BP      (1)
  ) u_dut_small (
    .CLK        (clk),
    .RST        (rst_s),
    .HSYNC      (hs_s),
    .VSYNC      (vs_s),
    .DEN        (den_s),
    .X          (x_s),
    .Y          (y_s),
    .FRAME_START(fs_s)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int   c;
    logic den;
    logic hs;
    logic vs;
    logic fs;
    int   x;
    int   y;
  } vec_t;

  localparam int NVec = 14;
  vec_t tbl[NVec];

  initial begin
    int c_now;
    int den_cnt, x_bad, hs_first, hs_len, fs_cnt, vs_len, hs_tot, guard;
    bit found;

    // Small panel vectors, indexed by counter step c after release
    // (h = c % 19, v = (c / 19) % 7), outputs seen just after edge c.
    tbl[0]  = '{0,   1'b1, 1'b1, 1'b1, 1'b1, 0,  0};
    tbl[1]  = '{15,  1'b1, 1'b1, 1'b1, 1'b0, 15, 0};
    tbl[2]  = '{16,  1'b0, 1'b1, 1'b1, 1'b0, 0,  0};
    tbl[3]  = '{17,  1'b0, 1'b0, 1'b1, 1'b0, 0,  0};
    tbl[4]  = '{18,  1'b0, 1'b1, 1'b1, 1'b0, 0,  0};
    tbl[5]  = '{19,  1'b1, 1'b1, 1'b1, 1'b0, 0,  1};
    tbl[6]  = '{72,  1'b1, 1'b1, 1'b1, 1'b0, 15, 3};
    tbl[7]  = '{76,  1'b0, 1'b1, 1'b1, 1'b0, 0,  0};
    tbl[8]  = '{95,  1'b0, 1'b1, 1'b0, 1'b0, 0,  0};
    tbl[9]  = '{112, 1'b0, 1'b0, 1'b0, 1'b0, 0,  0};
    tbl[10] = '{114, 1'b0, 1'b1, 1'b1, 1'b0, 0,  0};
    tbl[11] = '{132, 1'b0, 1'b1, 1'b1, 1'b0, 0,  0};
    tbl[12] = '{133, 1'b1, 1'b1, 1'b1, 1'b1, 0,  0};
    tbl[13] = '{134, 1'b1, 1'b1, 1'b1, 1'b0, 1,  0};

    // Reset held 5 clocks.
    repeat (5) @(posedge clk);
    #1;
    check("rst_hsync", int'(hs_d), 1);
    check("rst_vsync", int'(vs_d), 1);
    check("rst_den", int'(den_d), 0);
    check("rst_x", int'(x_d), 0);
    check("rst_y", int'(y_d), 0);
    check("rst_fs", int'(fs_d), 0);

    // Default panel: first line after release.
    @(negedge clk);
    rst_d = 1'b0;
    den_cnt = 0; x_bad = 0; hs_first = -1; hs_len = 0;
    for (int c = 0; c < 535; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        check("rel_den", int'(den_d), 1);
        check("rel_x", int'(x_d), 0);
        check("rel_y", int'(y_d), 0);
        check("rel_fs", int'(fs_d), 1);
      end
      if (den_d) begin
        den_cnt++;
        if (int'(x_d) != c || y_d != 0) x_bad++;
      end else if (x_d != 0 || y_d != 0) begin
        x_bad++;
      end
      if (!hs_d) begin
        if (hs_first < 0) hs_first = c;
        hs_len++;
      end
      if (c > 0 && fs_d) x_bad++;
      if (!vs_d) x_bad++;
    end
    check("line_den_count", den_cnt, 480);
    check("line_xy_errors", x_bad, 0);
    check("line_hsync_start", hs_first, 488);
    check("line_hsync_width", hs_len, 4);
    @(posedge clk);
    #1;
    check("line2_den", int'(den_d), 1);
    check("line2_x", int'(x_d), 0);
    check("line2_y", int'(y_d), 1);

    // Default panel: mid-frame async reset at Y=100, X=250.
    found = 1'b0;
    guard = 0;
    while (!found && guard < 60000) begin
      @(posedge clk);
      #1;
      guard++;
      if (den_d && y_d == 100 && x_d == 250) found = 1'b1;
    end
    check("mid_reach_point", int'(found), 1);
    rst_d = 1'b1;
    #1;
    check("mid_rst_den", int'(den_d), 0);
    check("mid_rst_x", int'(x_d), 0);
    check("mid_rst_y", int'(y_d), 0);
    check("mid_rst_hs", int'(hs_d), 1);
    check("mid_rst_vs", int'(vs_d), 1);
    check("mid_rst_fs", int'(fs_d), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_d = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rel_fs", int'(fs_d), 1);
    check("mid_rel_den", int'(den_d), 1);
    check("mid_rel_x", int'(x_d), 0);

    // Small panel: table-driven vectors across one frame and the wrap.
    @(negedge clk);
    rst_s = 1'b0;
    c_now = -1;
    for (int i = 0; i < NVec; i++) begin
      while (c_now < tbl[i].c) begin
        @(posedge clk);
        c_now++;
      end
      #1;
      check($sformatf("vec%0d_den", tbl[i].c), int'(den_s), int'(tbl[i].den));
      check($sformatf("vec%0d_hs", tbl[i].c), int'(hs_s), int'(tbl[i].hs));
      check($sformatf("vec%0d_vs", tbl[i].c), int'(vs_s), int'(tbl[i].vs));
      check($sformatf("vec%0d_fs", tbl[i].c), int'(fs_s), int'(tbl[i].fs));
      check($sformatf("vec%0d_x", tbl[i].c), int'(x_s), tbl[i].x);
      check($sformatf("vec%0d_y", tbl[i].c), int'(y_s), tbl[i].y);
    end

    // Small panel: whole-frame counts over two frames after a fresh reset.
    rst_s = 1'b1;
    #1;
    check("small_rst_fs", int'(fs_s), 0);
    @(negedge clk);
    rst_s = 1'b0;
    den_cnt = 0; fs_cnt = 0; vs_len = 0; hs_tot = 0;
    for (int c = 0; c < 266; c++) begin
      @(posedge clk);
      #1;
      if (den_s) den_cnt++;
      if (fs_s) fs_cnt++;
      if (!vs_s) vs_len++;
      if (!hs_s) hs_tot++;
      if (fs_s && (c % 133) != 0) fs_cnt += 100;
    end
    check("frame_den_count", den_cnt, 2 * 64);
    check("frame_fs_count", fs_cnt, 2);
    check("frame_vsync_low", vs_len, 2 * 19);
    check("frame_hsync_low", hs_tot, 2 * 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
